fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the fetch stage of the five-stage MIPS pipeline. Merges D-stage branch/jump resolution, hazard-unit stall requests and the multiply/divide unit's busy window into the fetch-stage PC enable and 2-bit next-PC select, plus the F/D hold and D/E bubble controls. Owns a small FSM and down-counter that track the multi-cycle mult/div occupancy, so the rest of the pipeline sees a single `md_busy` flag.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (legal range 1..2^CNT_W-1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (same range).
- `CNT_W`, default 4: busy counter width.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `br_take`  in  1  D-stage branch/jump resolved taken.
- `br_kind`  in  2  target kind: 01 PC-relative offset, 10 26-bit index (j/jal), 11 register (jr/jalr); 00 means none.
- `hz_stall`  in  1  data-hazard stall request from the hazard unit.
- `md_start`  in  1  E-stage mult/div issue pulse.
- `md_op`  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with `md_start`.
- `md_use`  in  1  D-stage instruction is mfhi/mflo/mthi/mtlo/mult/div.
- `pc_en`  out  1  fetch-stage PC write enable.
- `pcsrc`  out  2  next-PC select: 00 PC+4, 01 offset, 10 index, 11 register.
- `fd_en`  out  1  F/D pipeline register enable.
- `de_clr`  out  1  D/E pipeline register clear (bubble).
- `md_busy`  out  1  mult/div unit occupied.
- `stall_cycles`  out  32  stall cycle count (see Configuration).

## Operation
- `stall = hz_stall | (md_use & (md_busy | md_start))`.
- `stall`=1: `pc_en`=0, `fd_en`=0, `de_clr`=1, `pcsrc`=00. Branch resolution is ignored; the stalled branch re-resolves next cycle.
- `stall`=0: `pc_en`=1, `fd_en`=1, `de_clr`=0.
- `stall`=0, `pcsrc`: `br_take ? br_kind : 00`. `br_take`=1 with `br_kind`=00 yields 00.
- Delay slot: the instruction already in F always advances; `fetch_ctrl` never flushes F/D.
- FSM states:
  - RUN: `md_busy`=0. `md_start`=1 loads `cnt` with MULT_CYCLES (md_op[1]=0) or DIV_CYCLES (md_op[1]=1) and goes to BUSY.
  - BUSY: `md_busy`=1. `cnt` decrements each cycle. When `cnt`==1, go to RUN and clear `cnt` to 0.
- `md_start` while in BUSY is ignored: no reload and no state change. The pipeline prevents it via the `md_use` stall.
- All outputs except `stall_cycles` are combinational from the state and current inputs. State and `cnt` are the only flops besides the optional counter.

## Timing
- Reset asserted (low): state=RUN, `cnt`=0 and `stall_cycles`=0 immediately, independent of `clk`.
- Output values under reset with quiet inputs: `pc_en`=1, `fd_en`=1, `de_clr`=0, `pcsrc`=00, `md_busy`=0.
- Reset deassertion takes effect at the first rising edge after release.
- Reset asserted mid-BUSY aborts the window: `md_busy` falls in the same cycle.
- `md_start` sampled high at edge N: `md_busy` is high for cycles N+1 .. N+MULT_CYCLES (or DIV_CYCLES) and low at N+MULT_CYCLES+1.
- `md_use` coinciding with `md_start` stalls in that same cycle (0 cycles of latency).
- Back-to-back: `md_start` in the first RUN cycle after BUSY reloads normally, so there is no dead cycle.
- `hz_stall` and md stall overlapping: the stall outputs simply stay asserted; the counter is unaffected by stalls.

## Configuration
- Macro `FETCH_CTRL_PERF_EN`.
- Defined: `stall_cycles` is a 32-bit register. It increments on every rising edge with `pc_en`=0, saturates at 32'hFFFFFFFF, and is cleared only by reset.
- Undefined: no counter flops; `stall_cycles` is tied to 32'h0.

## Test plan
- Reset low with random inputs, then release, all inputs 0 -> `md_busy`=0, `pc_en`=1, `pcsrc`=00, `stall_cycles`=0.
- `br_take`=1, `br_kind`=11, `hz_stall`=0 -> `pcsrc`=11, `pc_en`=1. Same cycle with `hz_stall`=1 -> `pcsrc`=00, `pc_en`=0, `de_clr`=1.
- `md_start`=1, `md_op`=00 for one cycle -> `md_busy` high exactly 5 cycles. `md_use`=1 held throughout -> `pc_en`=0 for 6 cycles including the issue cycle. With `FETCH_CTRL_PERF_EN`, `stall_cycles`=6.
- `md_op`=10 issue, then a second `md_start` pulse 3 cycles later -> busy window still ends 10 cycles after the first issue, with no reload.
- Reset pulsed low at cycle 4 of a div window -> `md_busy`=0 immediately. After release, a fresh mult issue gives a full 5-cycle window.
- Div window ends and `md_start` with `md_op`=01 arrives in the first RUN cycle -> `md_busy` low for that cycle only, then high for 5 cycles.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// fetch_ctrl_if
//   Handshake bundle between the pipeline and the fetch sequencing controller.
//   Rev 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
    logic        br_take;
    logic [1:0]  br_kind;
    logic        hz_stall;
    logic        md_start;
    logic [1:0]  md_op;
    logic        md_use;
    logic        pc_en;
    logic [1:0]  pcsrc;
    logic        fd_en;
    logic        de_clr;
    logic        md_busy;
    logic [31:0] stall_cycles;

    modport master (
        output br_take, br_kind, hz_stall, md_start, md_op, md_use,
        input  pc_en, pcsrc, fd_en, de_clr, md_busy, stall_cycles
    );

    modport slave (
        input  br_take, br_kind, hz_stall, md_start, md_op, md_use,
        output pc_en, pcsrc, fd_en, de_clr, md_busy, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl
//   Fetch-stage sequencing: PC enable/select, F/D hold, D/E bubble and the
//   mult/div busy window. Optional stall counter under FETCH_CTRL_PERF_EN.
//   Rev 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    fetch_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_md_busy;
    logic             w_stall;
    logic             w_unused;

    // Only the mult/div distinction matters here; signedness is the unit's concern.
    assign w_unused = bus.md_op[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_md_busy   = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.md_start) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = bus.md_op[1] ? C_DIV_LOAD : C_MULT_LOAD;
                end
            end
            BUSY: begin
                w_md_busy = 1'b1;
                if (r_cnt == C_CNT_ONE) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - C_CNT_ONE;
                end
            end
        endcase
    end

    // A start in the same cycle as an md_use must already hold the pipeline.
    assign w_stall = bus.hz_stall | (bus.md_use & (w_md_busy | bus.md_start));

    always_comb begin
        bus.md_busy = w_md_busy;
        bus.pc_en   = ~w_stall;
        bus.fd_en   = ~w_stall;
        bus.de_clr  = w_stall;
        bus.pcsrc   = 2'b00;
        if (!w_stall && bus.br_take) begin
            bus.pcsrc = bus.br_kind;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= 32'h0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`else
    assign bus.stall_cycles = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fetch_ctrl
//   Randomised and directed bench for fetch_ctrl against a window-based model.
//   Rev 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the busy window is a range of interval indices [busy_lo, busy_hi];
    // interval k is the time between edge k and edge k+1.
    int          e_idx;
    int          busy_lo;
    int          busy_hi;
    logic [31:0] exp_sc;
    bit          chk_on;

    function automatic bit in_win(input int k);
        return (k >= busy_lo) && (k <= busy_hi);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        busy_lo = 1;
        busy_hi = 0;
        exp_sc  = 32'h0;
    endtask

    task automatic model_edge();
        bit bp;
        bit stl;
        int len;
        bp  = in_win(e_idx);
        if (reset) begin
            stl = bus.hz_stall | (bus.md_use & (bp | bus.md_start));
`ifdef FETCH_CTRL_PERF_EN
            if (stl && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
`endif
            if (bus.md_start && !bp) begin
                len     = bus.md_op[1] ? 10 : 5;
                busy_lo = e_idx + 1;
                busy_hi = e_idx + len;
            end
        end
        e_idx++;
    endtask

    task automatic apply(input logic r, input logic bt, input logic [1:0] bk, input logic hz,
                         input logic st, input logic [1:0] op, input logic u);
        @(posedge clk);
        model_edge();
        #1;
        reset        = r;
        bus.br_take  = bt;
        bus.br_kind  = bk;
        bus.hz_stall = hz;
        bus.md_start = st;
        bus.md_op    = op;
        bus.md_use   = u;
        if (!r) model_reset();
        chk_on = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            bit          b;
            bit          s;
            logic [1:0]  ps;
            b  = in_win(e_idx);
            s  = bus.hz_stall | (bus.md_use & (b | bus.md_start));
            ps = (!s && bus.br_take) ? bus.br_kind : 2'b00;
            chk("md_busy",      {31'd0, bus.md_busy}, {31'd0, b});
            chk("pc_en",        {31'd0, bus.pc_en},   {31'd0, ~s});
            chk("fd_en",        {31'd0, bus.fd_en},   {31'd0, ~s});
            chk("de_clr",       {31'd0, bus.de_clr},  {31'd0, s});
            chk("pcsrc",        {30'd0, bus.pcsrc},   {30'd0, ps});
            chk("stall_cycles", bus.stall_cycles,     exp_sc);
        end
    end

    initial begin
        int nbusy;
        int nstall;
        n_cmp  = 0;
        n_err  = 0;
        e_idx  = 0;
        chk_on = 1'b0;
        model_reset();
        reset        = 1'b0;
        bus.br_take  = 1'b0;
        bus.br_kind  = 2'b00;
        bus.hz_stall = 1'b0;
        bus.md_start = 1'b0;
        bus.md_op    = 2'b00;
        bus.md_use   = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
            chk("rst_busy", {31'd0, bus.md_busy}, 32'd0);
            chk("rst_sc",   bus.stall_cycles, 32'd0);
        end
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("rel_busy",  {31'd0, bus.md_busy}, 32'd0);
        chk("rel_pc_en", {31'd0, bus.pc_en},   32'd1);
        chk("rel_pcsrc", {30'd0, bus.pcsrc},   32'd0);
        chk("rel_sc",    bus.stall_cycles,     32'd0);

        // Register-target branch, then the same with a hazard stall.
        apply(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("br_pcsrc", {30'd0, bus.pcsrc}, 32'd3);
        chk("br_pc_en", {31'd0, bus.pc_en}, 32'd1);
        apply(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0);
        chk("hz_pcsrc",  {30'd0, bus.pcsrc},  32'd0);
        chk("hz_pc_en",  {31'd0, bus.pc_en},  32'd0);
        chk("hz_de_clr", {31'd0, bus.de_clr}, 32'd1);

        // Fresh counter, then a mult issue with md_use held.
        apply(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        nbusy  = 0;
        nstall = 0;
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1);
        nbusy  += bus.md_busy ? 1 : 0;
        nstall += bus.pc_en ? 0 : 1;
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
            nbusy  += bus.md_busy ? 1 : 0;
            nstall += bus.pc_en ? 0 : 1;
        end
        chk("mult_busy_len",  nbusy,  32'd5);
        chk("mult_stall_len", nstall, 32'd6);
`ifdef FETCH_CTRL_PERF_EN
        chk("mult_sc", bus.stall_cycles, 32'd6);
`else
        chk("mult_sc", bus.stall_cycles, 32'd0);
`endif
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);

        // Div issue with an ignored second start three cycles later.
        nbusy = 0;
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0);
        nbusy += bus.md_busy ? 1 : 0;
        for (int i = 0; i < 13; i++) begin
            apply(1'b1, 1'b0, 2'b00, 1'b0, (i == 2), 2'b00, 1'b0);
            nbusy += bus.md_busy ? 1 : 0;
        end
        chk("div_busy_len", nbusy, 32'd10);

        // Reset in the fourth cycle of a div window.
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("pre_abort_busy", {31'd0, bus.md_busy}, 32'd1);
        apply(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        chk("abort_busy", {31'd0, bus.md_busy}, 32'd0);
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        nbusy = 0;
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
            nbusy += bus.md_busy ? 1 : 0;
        end
        chk("post_abort_len", nbusy, 32'd5);

        // Back-to-back: multu issued in the first RUN cycle after a div.
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 10; i++) apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0);
        chk("b2b_gap", {31'd0, bus.md_busy}, 32'd0);
        nbusy = 0;
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
            nbusy += bus.md_busy ? 1 : 0;
        end
        chk("b2b_len", nbusy, 32'd5);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 63) != 0),
                  1'($urandom), 2'($urandom),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0),
                  2'($urandom),
                  ($urandom_range(0, 2) == 0));
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
